// File: rtl/rom_stream_reader.sv
// ---------------------------------------------------------------------------
// rom_stream_reader : burst reader from a 1-cycle-latency memory into a
//                     credit-limited FIFO feeding a ready/valid stream.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rom_stream_reader #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic [3:0]        m_byteenable,
  input  logic [31:0]       m_readdata,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              zero_done_q, zero_done_d;
  logic              strobe;

  logic [32:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_wr, fifo_rd, credit_ok, last_accept;

  // A word may be requested only if it is guaranteed a FIFO slot on return.
  assign credit_ok = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q})
                     < (CNT_W+1)'(FIFO_DEPTH);

  assign fifo_wr     = inflight_q;
  assign out_valid   = (count_q != '0);
  assign fifo_rd     = out_valid & out_ready;
  assign out_data    = mem_q[rd_ptr_q][31:0];
  assign out_last    = out_valid & mem_q[rd_ptr_q][32];
  assign last_accept = (state_q == S_DRAIN) & fifo_rd & out_last;

  assign busy         = (state_q != S_IDLE);
  assign done         = zero_done_q | last_accept;
  assign m_address    = addr_q;
  assign m_chipselect = strobe;
  assign m_byteenable = 4'hF;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    zero_done_d = 1'b0;
    strobe      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = length;
          if (length == '0) zero_done_d = 1'b1;
          else              state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          strobe   = 1'b1;
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - (ADDR_W+1)'(1);
          if (remain_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= strobe;
      inflight_last_q <= strobe & (remain_q == (ADDR_W+1)'(1));
      zero_done_q     <= zero_done_d;
      count_q         <= count_d;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= {inflight_last_q, m_readdata};
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_stream_reader : randomized self-checking bench with a queue-based
//                        reference of addresses, words and last flags.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rom_stream_reader;
  localparam int ADDR_W     = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset, start, out_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy, done, m_chipselect, out_valid, out_last;
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic [31:0]       m_readdata, out_data;

  rom_stream_reader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .m_address(m_address),
    .m_chipselect(m_chipselect), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [21:0] salt = '0;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {salt, a};
  endfunction

  // Memory: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk)
    m_readdata <= m_chipselect ? mem_word(m_address) : $urandom();

  int cyc = 0;
  int strobe_n, done_n, max_pend;
  int first_st_cyc, last_st_cyc, first_out_cyc, last_out_cyc;
  int addr_log[$];
  logic [31:0] data_log[$];
  bit last_log[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m_chipselect) begin
      if (strobe_n == 0) first_st_cyc = cyc;
      last_st_cyc = cyc;
      strobe_n++;
      addr_log.push_back(int'(m_address));
    end
    if (out_valid && out_ready) begin
      if (data_log.size() == 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      data_log.push_back(out_data);
      last_log.push_back(out_last);
    end
    if (done) done_n++;
    if (strobe_n - data_log.size() > max_pend) max_pend = strobe_n - data_log.size();
  end

  task automatic clear_log();
    strobe_n = 0; done_n = 0; max_pend = 0;
    addr_log.delete(); data_log.delete(); last_log.delete();
  endtask

  // Called one time unit after a rising edge; returns in the same phase.
  task automatic drive_start(input int b, input int l);
    start = 1'b1; base_addr = ADDR_W'(b); length = (ADDR_W+1)'(l);
    @(posedge clk); #1;
    start = 1'b0; base_addr = ADDR_W'($urandom()); length = (ADDR_W+1)'($urandom());
  endtask

  task automatic run_until_done(input int budget, input int mode, input bit inject,
                                output bit timed_out);
    int n = 0;
    int d0 = done_n;
    while (done_n == d0 && n < budget) begin
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (inject && busy && $urandom_range(0, 2) == 0) begin
        start = 1'b1; base_addr = ADDR_W'($urandom());
        length = (ADDR_W+1)'($urandom_range(1, 8));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; out_ready = 1'b1;
    timed_out = (done_n == d0);
  endtask

  task automatic score(input string nm, input int base, input int len, input int exp_done);
    int bad_a = 0, bad_d = 0, bad_l = 0;
    checks++;
    if (strobe_n != len) begin
      errors++; $display("FAIL %s strobe count: got %0d expected %0d", nm, strobe_n, len);
    end
    for (int i = 0; i < addr_log.size() && i < len; i++)
      if (addr_log[i] != (base + i) % MEM_WORDS) bad_a++;
    checks++;
    if (bad_a != 0) begin
      errors++; $display("FAIL %s addresses: %0d wrong, first got 0x%0h expected 0x%0h",
                         nm, bad_a, addr_log.size() > 0 ? addr_log[0] : -1, base % MEM_WORDS);
    end
    checks++;
    if (data_log.size() != len) begin
      errors++; $display("FAIL %s word count: got %0d expected %0d", nm, data_log.size(), len);
    end
    for (int i = 0; i < data_log.size() && i < len; i++) begin
      if (data_log[i] !== mem_word(ADDR_W'((base + i) % MEM_WORDS))) bad_d++;
      if (last_log[i] !== (i == len - 1)) bad_l++;
    end
    checks++;
    if (bad_d != 0) begin
      errors++; $display("FAIL %s data: %0d words differ from expected", nm, bad_d);
    end
    checks++;
    if (bad_l != 0) begin
      errors++; $display("FAIL %s out_last: %0d words tagged wrongly", nm, bad_l);
    end
    checks++;
    if (done_n != exp_done) begin
      errors++; $display("FAIL %s done pulses: got %0d expected %0d", nm, done_n, exp_done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy after done: got %b expected 0", nm, busy);
    end
  endtask

  task automatic timeout_check(input string nm, input bit to);
    checks++;
    if (to) begin errors++; $display("FAIL %s timeout: got no done expected done", nm); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    base_addr = '0; length = '0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy, done, m_chipselect, out_valid, out_last} !== 5'b0) begin
      errors++; $display("FAIL reset flags: got %b expected 00000",
                         {busy, done, m_chipselect, out_valid, out_last});
    end
    checks++;
    if (m_address !== '0) begin
      errors++; $display("FAIL reset m_address: got 0x%0h expected 0x0", m_address);
    end
    checks++;
    if (m_byteenable !== 4'hF) begin
      errors++; $display("FAIL byteenable: got 0x%0h expected 0xF", m_byteenable);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit to;
    salt = '0; clear_log();
    drive_start(16, 4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic busy: got %b expected 1", busy); end
    run_until_done(200, 0, 0, to);
    timeout_check("basic", to);
    score("basic", 16, 4, 1);
    checks++;
    if (last_st_cyc - first_st_cyc != 3) begin
      errors++; $display("FAIL basic strobe span: got %0d expected 3", last_st_cyc - first_st_cyc);
    end
    checks++;
    if (last_out_cyc - first_out_cyc != 3) begin
      errors++; $display("FAIL basic output span: got %0d expected 3", last_out_cyc - first_out_cyc);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int base = $urandom_range(0, MEM_WORDS - 1);
    int unstable = 0;
    salt = 22'($urandom()); clear_log();
    out_ready = 1'b0;
    drive_start(base, 8);
    for (int i = 0; i < 20; i++) begin
      if (i >= 4 && (out_valid !== 1'b1 || out_last !== 1'b0 ||
                     out_data !== mem_word(ADDR_W'(base)))) unstable++;
      @(posedge clk); #1;
    end
    checks++;
    if (strobe_n != FIFO_DEPTH) begin
      errors++; $display("FAIL backpressure strobes: got %0d expected %0d", strobe_n, FIFO_DEPTH);
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL backpressure hold: got %0d unstable cycles expected 0", unstable);
    end
    run_until_done(300, 1, 0, to);
    timeout_check("backpressure", to);
    score("backpressure", base, 8, 1);
  endtask

  task automatic test_wrap();
    bit to;
    salt = 22'($urandom()); clear_log();
    drive_start(10'h3FE, 4);
    run_until_done(200, 1, 0, to);
    timeout_check("wrap", to);
    score("wrap", 10'h3FE, 4, 1);
  endtask

  task automatic test_zero_len();
    clear_log();
    drive_start($urandom_range(0, MEM_WORDS - 1), 0);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL zero done/busy: got %b expected 10", {done, busy});
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (done_n != 1 || strobe_n != 0) begin
      errors++; $display("FAIL zero pulses/strobes: got %0d/%0d expected 1/0", done_n, strobe_n);
    end
  endtask

  task automatic test_full_len();
    bit to;
    int base = $urandom_range(0, MEM_WORDS - 1);
    salt = 22'($urandom()); clear_log();
    drive_start(base, MEM_WORDS);
    run_until_done(6000, 1, 0, to);
    timeout_check("full", to);
    score("full", base, MEM_WORDS, 1);
    checks++;
    if (max_pend > FIFO_DEPTH) begin
      errors++; $display("FAIL full occupancy: got %0d expected <= %0d", max_pend, FIFO_DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int s0, w0;
    int base = $urandom_range(0, MEM_WORDS - 1);
    salt = 22'($urandom()); clear_log();
    out_ready = 1'b1;
    drive_start(base, 8);
    for (int i = 0; i < 50 && data_log.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1; start = 1'b1; length = 11'd4;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, m_chipselect, out_valid, out_last} !== 5'b0 || m_address !== '0) begin
      errors++; $display("FAIL midreset outputs: got %b addr 0x%0h expected 00000 addr 0x0",
                         {busy, done, m_chipselect, out_valid, out_last}, m_address);
    end
    s0 = strobe_n; w0 = data_log.size();
    repeat (4) @(posedge clk); #1;
    checks++;
    if (strobe_n != s0 || data_log.size() != w0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset quiet: got %0d strobes %0d words busy %b expected 0 0 0",
                         strobe_n - s0, data_log.size() - w0, busy);
    end
    clear_log();
    base = $urandom_range(0, MEM_WORDS - 1);
    drive_start(base, 5);
    run_until_done(200, 1, 0, to);
    timeout_check("restart", to);
    score("restart", base, 5, 1);
  endtask

  task automatic test_back_to_back();
    bit to;
    int b1 = $urandom_range(0, MEM_WORDS - 1);
    int b2 = $urandom_range(0, MEM_WORDS - 1);
    salt = 22'($urandom()); clear_log();
    drive_start(b1, 3);
    run_until_done(200, 1, 1, to);
    timeout_check("b2b first", to);
    checks++;
    if (strobe_n != 3 || data_log.size() != 3 || done_n != 1) begin
      errors++; $display("FAIL b2b first: got %0d strobes %0d words %0d done expected 3 3 1",
                         strobe_n, data_log.size(), done_n);
    end
    clear_log();
    drive_start(b2, 2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b accept: got busy %b expected 1", busy); end
    run_until_done(200, 1, 1, to);
    timeout_check("b2b second", to);
    score("b2b", b2, 2, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_full_len();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
